demux1to2_stream: RTL
=====================

# demux1to2_stream

Buffered 1-to-2 stream demultiplexer: each input beat carries a select bit that routes it to output A (sel=0) or output B (sel=1). It is the distribution-side counterpart of the 2-to-1 select path in the datapath library. Each output has an independent 2-entry FIFO, so a stalled output never blocks beats bound for the other. Per-output beat order is preserved, and the default data width matches the 4-bit adder datapath.

## Interface
- WIDTH, 4, data width of every beat
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when high with in_valid
- in_sel  in  1  destination: 0 = A, 1 = B; sampled with in_data
- in_data  in  WIDTH  input payload
- a_valid  out  1  A output FIFO non-empty
- a_ready  in  1  A consumer ready
- a_data  out  WIDTH  head of A FIFO
- b_valid  out  1  B output FIFO non-empty
- b_ready  in  1  B consumer ready
- b_data  out  WIDTH  head of B FIFO
- a_count  out  8  beats delivered on A, mod 256 (only with DEMUX_COUNT_EN)
- b_count  out  8  beats delivered on B, mod 256 (only with DEMUX_COUNT_EN)

## Operation
- Two identical FIFOs (A, B), depth 2. Each FIFO has a 1-bit write pointer, a 1-bit read pointer and a 2-bit occupancy count.
- in_ready = !rst && !full[in_sel]. This is combinational on in_sel only. No path exists from a_ready/b_ready to in_ready.
- Push: in_valid && in_ready writes in_data into FIFO[in_sel]. The other FIFO is untouched.
- Pop: x_valid && x_ready removes the head of FIFO x.
- Simultaneous push and pop on the same FIFO: occupancy is unchanged and both pointers advance.
  - On a full FIFO the push is refused (in_ready=0), even if a pop happens in the same cycle.
  - On an empty FIFO there is no pop, so only the push applies.
- x_valid = (count_x != 0). x_data = mem_x[rd_ptr_x], driven from registers. x_data is don't-care while x_valid=0, but reads 0 after reset.
- Pointers wrap modulo 2. count_x never exceeds 2 and never goes below 0.
- in_sel and in_data only matter when in_valid=1. Sender-side rule: hold in_sel and in_data stable while in_valid=1 and in_ready=0.
- The block does not check X on in_sel. The bench must never drive X on in_sel while in_valid=1.

## Timing
- Reset values: a_valid=0, b_valid=0, a_data=0, b_data=0, all pointers and counts 0. With the macro defined, a_count=0 and b_count=0.
- in_ready=0 while rst=1, and goes to 1 in the first cycle after rst deasserts.
- Latency: a beat accepted at edge N appears on x_valid/x_data after edge N, so it can be consumed at edge N+1.
- Throughput: one beat per cycle per output when the consumer holds ready=1. The input sustains one beat per cycle in any A/B mix.
- Reset mid-operation flushes both FIFOs in one cycle. In-flight beats are dropped without any indication.
- Output handshake: once x_valid=1, x_valid and x_data stay stable until a pop occurs.

## Configuration
- DEMUX_COUNT_EN defined:
  - a_count and b_count ports exist.
  - Each counter increments on every completed pop of its output.
  - Each counter wraps from 255 to 0 and clears on rst.
- DEMUX_COUNT_EN undefined:
  - The ports and counter logic are absent.
  - Routing behaviour is identical.

## Test plan
- Reset: hold rst=1 for 3 cycles with in_valid=1 -> in_ready=0, a_valid=b_valid=0, data outputs 0, no beats queued after rst falls.
- Routing: with a_ready=b_ready=1, send 0x3 (sel=0) then 0x9 (sel=1) back-to-back -> a_data=0x3 one cycle after acceptance; b_data=0x9 the following cycle; each valid high exactly one cycle.
- Isolation: hold a_ready=0 and send four sel=0 beats 0x1..0x4 -> first two accepted, then in_ready=0. A following sel=1 beat 0xF is accepted at once and delivered on B. Release a_ready -> A emits 0x1, 0x2 in order.
- Full with simultaneous pop: fill A with 0x5, 0x6, then raise a_ready in the same cycle as a sel=0 beat 0x7 -> 0x7 refused that cycle and accepted the next. A emits 0x5, 0x6, 0x7.
- Mid-stream reset: with both FIFOs holding 2 beats, pulse rst for 1 cycle -> both valids 0 on the next cycle, and the next accepted beat appears with no stale data.
- DEMUX_COUNT_EN: stream 257 beats to A with a_ready=1 and 3 to B -> a_count=1 (wrapped), b_count=3. Compiled without the macro, the same stream yields an identical data sequence.

Source files
------------

// File: rtl/demux1to2_stream.sv
// demux1to2_stream: buffered 1-to-2 stream demultiplexer.
// Each input beat is steered by in_sel into an independent 2-entry FIFO
// (A for sel=0, B for sel=1), so a stalled consumer only blocks its own lane.
// Optional feature macro: DEMUX_COUNT_EN adds a_count/b_count delivered-beat
// counters (mod 256); without it the routing logic is identical.
module demux1to2_stream #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [7:0]       a_count,
  output logic [7:0]       b_count
`endif
);

  logic [WIDTH-1:0] mem_a [2];
  logic [WIDTH-1:0] mem_b [2];
  logic             wr_ptr_a;
  logic             rd_ptr_a;
  logic [1:0]       count_a;
  logic             wr_ptr_b;
  logic             rd_ptr_b;
  logic [1:0]       count_b;

  logic full_a;
  logic full_b;
  logic push_a;
  logic push_b;
  logic pop_a;
  logic pop_b;

  // Acceptance depends only on the selected lane's fullness, never on a_ready/b_ready.
  always_comb begin
    full_a   = (count_a == 2'd2);
    full_b   = (count_b == 2'd2);
    in_ready = !rst && (in_sel ? !full_b : !full_a);
    push_a   = in_valid && in_ready && !in_sel;
    push_b   = in_valid && in_ready && in_sel;
    pop_a    = a_valid && a_ready;
    pop_b    = b_valid && b_ready;
  end

  assign a_valid = (count_a != 2'd0);
  assign b_valid = (count_b != 2'd0);
  assign a_data  = mem_a[rd_ptr_a];
  assign b_data  = mem_b[rd_ptr_b];

  // Lane A FIFO: storage, wrapping pointers and occupancy; reset clears storage so a_data reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_a[0] <= '0;
      mem_a[1] <= '0;
      wr_ptr_a <= 1'b0;
      rd_ptr_a <= 1'b0;
      count_a  <= 2'd0;
    end else begin
      if (push_a) begin
        mem_a[wr_ptr_a] <= in_data;
        wr_ptr_a        <= ~wr_ptr_a;
      end
      if (pop_a) begin
        rd_ptr_a <= ~rd_ptr_a;
      end
      case ({push_a, pop_a})
        2'b10:   count_a <= count_a + 2'd1;
        2'b01:   count_a <= count_a - 2'd1;
        default: count_a <= count_a;
      endcase
    end
  end

  // Lane B FIFO: mirror of lane A, fed only by sel=1 beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_b[0] <= '0;
      mem_b[1] <= '0;
      wr_ptr_b <= 1'b0;
      rd_ptr_b <= 1'b0;
      count_b  <= 2'd0;
    end else begin
      if (push_b) begin
        mem_b[wr_ptr_b] <= in_data;
        wr_ptr_b        <= ~wr_ptr_b;
      end
      if (pop_b) begin
        rd_ptr_b <= ~rd_ptr_b;
      end
      case ({push_b, pop_b})
        2'b10:   count_b <= count_b + 2'd1;
        2'b01:   count_b <= count_b - 2'd1;
        default: count_b <= count_b;
      endcase
    end
  end

`ifdef DEMUX_COUNT_EN
  // Delivered-beat counters: one increment per completed pop, wrapping at 256.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_count <= 8'd0;
      b_count <= 8'd0;
    end else begin
      if (pop_a) a_count <= a_count + 8'd1;
      if (pop_b) b_count <= b_count + 8'd1;
    end
  end
`endif

endmodule
